// File: rtl/timer_counter_n.sv
// WIDTH-bit timer/counter with Normal/CTC modes, TOV/OCF flags and optional fast PWM.
// Define TIMER_PWM_EN to enable fast PWM in mode 2'b10 with a buffered compare register.
module timer_counter_n #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OCR_RESET = 0
) (
  input  logic             sysClock,
  input  logic             reset,
  input  logic             count_tick,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] TCNT_data,
  input  logic             TCNT_write_enable,
  input  logic [WIDTH-1:0] OCR_data,
  input  logic             OCR_write_enable,
  input  logic [1:0]       flag_clear,
  output logic [WIDTH-1:0] TCNT_output,
  output logic [WIDTH-1:0] OCR_output,
  output logic [7:0]       TIFR_output,
  output logic             TIFR_write_enable,
  output logic             OC_out
);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_CTC    = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] OCR_INIT = WIDTH'(OCR_RESET);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  mode_e mode_w;
  assign mode_w = mode_e'(mode);

  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic [WIDTH-1:0] ocr_act_q, ocr_act_d;
  logic             tov_q, tov_d;
  logic             ocf_q, ocf_d;
  logic             twe_q, twe_d;
  logic             oc_q, oc_d;

  logic             is_ctc;
  logic             evt_match;
  logic             evt_top;
  logic             set_tov;
  logic             set_ocf;

`ifdef TIMER_PWM_EN
  logic [WIDTH-1:0] ocr_buf_q, ocr_buf_d;
  logic             pwm_q, pwm_d;
  logic             is_pwm;
`endif

  // Events are qualified by the tick and suppressed on a preload cycle.
  always_comb begin
    is_ctc    = (mode_w == MODE_CTC);
    evt_match = count_tick & ~TCNT_write_enable & (tcnt_q == ocr_act_q);
    evt_top   = count_tick & ~TCNT_write_enable & (tcnt_q == CNT_MAX);
    set_tov   = evt_top;
    set_ocf   = evt_match;

    tcnt_d = tcnt_q;
    if (TCNT_write_enable) begin
      tcnt_d = TCNT_data;
    end else if (count_tick) begin
      if (is_ctc && evt_match) begin
        tcnt_d = '0;
      end else begin
        tcnt_d = tcnt_q + WIDTH'(1);
      end
    end

    tov_d = set_tov | (tov_q & ~flag_clear[0]);
    ocf_d = set_ocf | (ocf_q & ~flag_clear[1]);
    twe_d = set_tov | set_ocf;
  end

`ifdef TIMER_PWM_EN
  // In PWM the active compare only changes at Top, or when PWM is left.
  always_comb begin
    is_pwm    = (mode_w == MODE_PWM);
    pwm_d     = is_pwm;
    ocr_act_d = ocr_act_q;
    ocr_buf_d = ocr_buf_q;
    oc_d      = oc_q;
    if (is_pwm) begin
      if (OCR_write_enable) ocr_buf_d = OCR_data;
      if (evt_top) ocr_act_d = ocr_buf_q;
      if (evt_top) begin
        oc_d = 1'b1;
      end else if (evt_match) begin
        oc_d = 1'b0;
      end
    end else begin
      oc_d = 1'b0;
      if (pwm_q) ocr_act_d = ocr_buf_q;
      if (OCR_write_enable) begin
        ocr_act_d = OCR_data;
        ocr_buf_d = OCR_data;
      end
    end
  end
`else
  always_comb begin
    ocr_act_d = ocr_act_q;
    oc_d      = 1'b0;
    if (OCR_write_enable) ocr_act_d = OCR_data;
  end
`endif

  always_ff @(posedge sysClock) begin
    if (reset) begin
      tcnt_q    <= '0;
      ocr_act_q <= OCR_INIT;
      tov_q     <= 1'b0;
      ocf_q     <= 1'b0;
      twe_q     <= 1'b0;
      oc_q      <= 1'b0;
    end else begin
      tcnt_q    <= tcnt_d;
      ocr_act_q <= ocr_act_d;
      tov_q     <= tov_d;
      ocf_q     <= ocf_d;
      twe_q     <= twe_d;
      oc_q      <= oc_d;
    end
  end

`ifdef TIMER_PWM_EN
  always_ff @(posedge sysClock) begin
    if (reset) begin
      ocr_buf_q <= OCR_INIT;
      pwm_q     <= 1'b0;
    end else begin
      ocr_buf_q <= ocr_buf_d;
      pwm_q     <= pwm_d;
    end
  end
`endif

  assign TCNT_output       = tcnt_q;
  assign OCR_output        = ocr_act_q;
  assign TIFR_output       = {6'b0, ocf_q, tov_q};
  assign TIFR_write_enable = twe_q;
  assign OC_out            = oc_q;

endmodule

// File: tb/tb_timer_counter_n.sv
// Self-checking bench for timer_counter_n (WIDTH=8): vector table, CTC loop, mode 10 sequences.
module tb_timer_counter_n;

  logic       clk;
  logic       reset;
  logic       count_tick;
  logic [1:0] mode;
  logic [7:0] TCNT_data;
  logic       TCNT_write_enable;
  logic [7:0] OCR_data;
  logic       OCR_write_enable;
  logic [1:0] flag_clear;
  logic [7:0] TCNT_output;
  logic [7:0] OCR_output;
  logic [7:0] TIFR_output;
  logic       TIFR_write_enable;
  logic       OC_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic       tick;
    logic [1:0] md;
    logic [7:0] tdata;
    logic       twe;
    logic [7:0] odata;
    logic       owe;
    logic [1:0] fclr;
    logic [7:0] e_tcnt;
    logic [7:0] e_ocr;
    logic [7:0] e_tifr;
    logic       e_twe;
    logic       e_oc;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] tcnt;
    logic [7:0] ocr;
    logic [7:0] tifr;
    logic       twe;
    logic       oc;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  timer_counter_n #(.WIDTH(8), .OCR_RESET(0)) dut (
    .sysClock          (clk),
    .reset             (reset),
    .count_tick        (count_tick),
    .mode              (mode),
    .TCNT_data         (TCNT_data),
    .TCNT_write_enable (TCNT_write_enable),
    .OCR_data          (OCR_data),
    .OCR_write_enable  (OCR_write_enable),
    .flag_clear        (flag_clear),
    .TCNT_output       (TCNT_output),
    .OCR_output        (OCR_output),
    .TIFR_output       (TIFR_output),
    .TIFR_write_enable (TIFR_write_enable),
    .OC_out            (OC_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic tick, input logic [1:0] md,
                       input logic [7:0] tdata, input logic twe,
                       input logic [7:0] odata, input logic owe, input logic [1:0] fclr);
    @(negedge clk);
    reset             = rst;
    count_tick        = tick;
    mode              = md;
    TCNT_data         = tdata;
    TCNT_write_enable = twe;
    OCR_data          = odata;
    OCR_write_enable  = owe;
    flag_clear        = fclr;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input vec_t v);
    exp_t e, got;
    e.name = name;
    e.tcnt = v.e_tcnt;
    e.ocr  = v.e_ocr;
    e.tifr = v.e_tifr;
    e.twe  = v.e_twe;
    e.oc   = v.e_oc;
    sb.push_back(e);
    drive(v.rst, v.tick, v.md, v.tdata, v.twe, v.odata, v.owe, v.fclr);
    got = sb.pop_front();
    check({got.name, " tcnt"}, int'(TCNT_output), int'(got.tcnt));
    check({got.name, " ocr"},  int'(OCR_output),  int'(got.ocr));
    check({got.name, " tifr"}, int'(TIFR_output), int'(got.tifr));
    check({got.name, " twe"},  int'(TIFR_write_enable), int'(got.twe));
    check({got.name, " oc"},   int'(OC_out),      int'(got.oc));
  endtask

  initial begin
    vec_t v;
    int   hi;
    reset = 1'b1; count_tick = 1'b0; mode = 2'b00; TCNT_data = '0;
    TCNT_write_enable = 1'b0; OCR_data = '0; OCR_write_enable = 1'b0; flag_clear = '0;

    //          rst tick md   tdata  twe odata  owe fclr   tcnt   ocr    tifr   twe oc
    tbl.push_back('{1, 1, 2'd0, 8'hAA, 1, 8'h77, 1, 2'b11, 8'h00, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{1, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 0, 2'd0, 8'hFD, 1, 8'h00, 0, 2'b00, 8'hFD, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'hFE, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'hFF, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 8'h01, 1, 0});
    tbl.push_back('{0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 8'h01, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h01, 8'h00, 8'h03, 1, 0});
    tbl.push_back('{0, 0, 2'd0, 8'hFF, 1, 8'h00, 0, 2'b00, 8'hFF, 8'h00, 8'h03, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b01, 8'h00, 8'h00, 8'h03, 1, 0});
    tbl.push_back('{0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'b01, 8'h00, 8'h00, 8'h02, 0, 0});
    tbl.push_back('{0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'b10, 8'h00, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 0, 2'd0, 8'h00, 0, 8'h10, 1, 2'b00, 8'h00, 8'h10, 8'h00, 0, 0});
    tbl.push_back('{0, 0, 2'd0, 8'h10, 1, 8'h00, 0, 2'b00, 8'h10, 8'h10, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h33, 1, 8'h00, 0, 2'b00, 8'h33, 8'h10, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h34, 8'h10, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd3, 8'h00, 0, 8'h00, 0, 2'b00, 8'h35, 8'h10, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h36, 1, 2'b00, 8'h36, 8'h36, 8'h00, 0, 0});
    tbl.push_back('{0, 1, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h37, 8'h36, 8'h02, 1, 0});
    tbl.push_back('{1, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0});

    for (int i = 0; i < tbl.size(); i++) step($sformatf("vec%0d", i), tbl[i]);

    // CTC with OCR=5: 0..5 twice, OCF at each 5->0, cleared on tick 7.
    v = '{0, 0, 2'd1, 8'h00, 0, 8'h05, 1, 2'b00, 8'h00, 8'h05, 8'h00, 0, 0};
    step("ctc_ocr", v);
    for (int k = 1; k <= 12; k++) begin
      v = '{0, 1, 2'd1, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 8'h05, 8'h00, 0, 0};
      if (k == 7) v.fclr = 2'b10;
      v.e_tcnt = 8'(k % 6);
      if (k % 6 == 0) begin
        v.e_tifr = 8'h02;
        v.e_twe  = 1'b1;
      end else if (k > 6 && k < 12) begin
        v.e_tifr = 8'h00;
      end
      step($sformatf("ctc_tick%0d", k), v);
    end

    v = '{1, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 8'h00, 8'h00, 0, 0};
    step("rst2", v);

`ifdef TIMER_PWM_EN
    v = '{0, 0, 2'd0, 8'h00, 0, 8'd64, 1, 2'b00, 8'h00, 8'd64, 8'h00, 0, 0};
    step("pwm_ocr64", v);
    for (int i = 0; i < 256; i++) drive(0, 1, 2'd2, 8'h00, 0, 8'h00, 0, 2'b00);
    check("pwm_wrap tcnt", int'(TCNT_output), 0);
    check("pwm_wrap oc", int'(OC_out), 1);
    check("pwm_wrap tov", int'(TIFR_output[0]), 1);
    hi = 1;
    for (int i = 1; i < 256; i++) begin
      drive(0, 1, 2'd2, 8'h00, 0, 8'd192, (i == 100), 2'b00);
      if (i == 100) check("pwm_buffered ocr", int'(OCR_output), 64);
      hi += int'(OC_out);
    end
    check("pwm_duty65", hi, 65);
    drive(0, 1, 2'd2, 8'h00, 0, 8'h00, 0, 2'b00);
    check("pwm_copy ocr", int'(OCR_output), 192);
    check("pwm_copy oc", int'(OC_out), 1);
    hi = 1;
    for (int i = 1; i < 256; i++) begin
      drive(0, 1, 2'd2, 8'h00, 0, 8'h00, 0, 2'b00);
      hi += int'(OC_out);
    end
    check("pwm_duty193", hi, 193);
    drive(0, 0, 2'd2, 8'h00, 0, 8'hFF, 1, 2'b00);
    check("pwm_max buf ocr", int'(OCR_output), 192);
    drive(0, 1, 2'd2, 8'h00, 0, 8'h00, 0, 2'b00);
    check("pwm_max ocr", int'(OCR_output), 255);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 2'd2, 8'h00, 0, 8'h00, 0, 2'b00);
      hi += int'(OC_out);
    end
    check("pwm_const_high", hi, 256);
    drive(0, 0, 2'd2, 8'h00, 0, 8'h10, 1, 2'b00);
    check("pwm_leave pre ocr", int'(OCR_output), 255);
    drive(0, 0, 2'd0, 8'h00, 0, 8'h00, 0, 2'b00);
    check("pwm_leave ocr", int'(OCR_output), 16);
    check("pwm_leave oc", int'(OC_out), 0);
`else
    // Mode 10 without PWM support behaves as Normal and OC_out stays low.
    v = '{0, 0, 2'd2, 8'hFE, 1, 8'hC0, 1, 2'b00, 8'hFE, 8'hC0, 8'h00, 0, 0};
    step("m2_preload", v);
    v = '{0, 1, 2'd2, 8'h00, 0, 8'h00, 0, 2'b00, 8'hFF, 8'hC0, 8'h00, 0, 0};
    step("m2_tick1", v);
    v = '{0, 1, 2'd2, 8'h00, 0, 8'h00, 0, 2'b00, 8'h00, 8'hC0, 8'h01, 1, 0};
    step("m2_wrap", v);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
